// File: rtl/bet_pkg.sv
// Shared types and constants for the Block Erase Table port sequencer.
package bet_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int BET_SIZE_DEF = 4096;
  localparam int CNT_W_DEF    = 32;
  localparam int RAM_RD_LAT   = 1;

  localparam logic WL_OP_READ  = 1'b0;
  localparam logic WL_OP_CLEAR = 1'b1;

  typedef enum logic [3:0] {
    INIT_SWEEP,
    IDLE,
    E_RD,
    E_CHK,
    E_WR,
    W_RD,
    W_CHK,
    CLR_SWEEP,
    ACK
  } bet_state_e;

endpackage

// File: rtl/bet_port_sequencer_if.sv
// Requester-side bus of the BET sequencer: erase-notify path and wear-leveling path.
interface bet_port_sequencer_if #(
  parameter int ADDR_W = 12
);
  // Handshake: req is a level held (with stable addr/op) until the matching
  // ack pulses for one cycle; the requester drops req in the cycle after ack,
  // and a req still high when the sequencer is idle counts as a new request.
  logic              erase_req;
  logic [ADDR_W-1:0] erase_addr;
  logic              erase_ack;
  logic              wl_req;
  logic              wl_op;
  logic [ADDR_W-1:0] wl_addr;
  logic              wl_ack;
  logic              wl_rdata;

  modport master (
    output erase_req, erase_addr, wl_req, wl_op, wl_addr,
    input  erase_ack, wl_ack, wl_rdata
  );

  modport slave (
    input  erase_req, erase_addr, wl_req, wl_op, wl_addr,
    output erase_ack, wl_ack, wl_rdata
  );
endinterface

// File: rtl/bet_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = erase, bit 1 = wear-leveling.
module bet_rr_arb2 (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);
  logic favour_wl;

  always_comb begin
    grant = req;
    if (&req) grant = favour_wl ? 2'b10 : 2'b01;
  end

  // The pointer only moves when both sides actually contended.
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) favour_wl <= 1'b0;
    else if (update && (&req)) favour_wl <= ~favour_wl;
  end
endmodule

// File: rtl/bet_port_sequencer.sv
// Serialises all accesses to the single-port 1-bit BET RAM and keeps erase/flag counts.
module bet_port_sequencer
  import bet_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BET_SIZE = BET_SIZE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk_50,
  input  logic                rst,
  bet_port_sequencer_if.slave bus,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_w_en,
  output logic                ram_w,
  input  logic                ram_r,
  output logic [CNT_W-1:0]    e_cnt,
  output logic [ADDR_W:0]     f_cnt,
  output logic                init_done,
  output bet_state_e          dbg_state
);
  localparam logic [ADDR_W:0] SWEEP_END = (ADDR_W+1)'(BET_SIZE);

  bet_state_e      state;
  logic [ADDR_W:0] sweep_cnt;
  logic [1:0]      grant;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  bet_rr_arb2 u_arb (
    .clk_50 (clk_50),
    .rst    (rst),
    .req    ({bus.wl_req, bus.erase_req}),
    .update (state == IDLE),
    .grant  (grant)
  );

  assign dbg_state = state;

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state         <= INIT_SWEEP;
      sweep_cnt     <= '0;
      ram_addr      <= '0;
      ram_w_en      <= 1'b0;
      ram_w         <= 1'b0;
      e_cnt         <= '0;
      f_cnt         <= '0;
      init_done     <= 1'b0;
      bus.erase_ack <= 1'b0;
      bus.wl_ack    <= 1'b0;
      bus.wl_rdata  <= 1'b0;
    end else begin
      bus.erase_ack <= 1'b0;
      bus.wl_ack    <= 1'b0;
      case (state)
        // Both sweeps share the zero-fill walk; the counter is one bit wider
        // than the address so the end compare cannot wrap.
        INIT_SWEEP, CLR_SWEEP: begin
          if (sweep_cnt == SWEEP_END) begin
            ram_w_en  <= 1'b0;
            sweep_cnt <= '0;
            if (state == INIT_SWEEP) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              e_cnt      <= '0;
              f_cnt      <= '0;
              bus.wl_ack <= 1'b1;
              state      <= ACK;
            end
          end else begin
            ram_addr  <= sweep_cnt[ADDR_W-1:0];
            ram_w_en  <= 1'b1;
            ram_w     <= 1'b0;
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (grant[0]) begin
            ram_addr <= bus.erase_addr;
            state    <= E_RD;
          end else if (grant[1]) begin
            if (bus.wl_op == WL_OP_CLEAR) begin
              ram_addr  <= '0;
              ram_w_en  <= 1'b1;
              ram_w     <= 1'b0;
              sweep_cnt <= {{ADDR_W{1'b0}}, 1'b1};
              state     <= CLR_SWEEP;
            end else begin
              ram_addr <= bus.wl_addr;
              state    <= W_RD;
            end
          end
        end
        E_RD:  state <= E_CHK;
        E_CHK: begin
          if (!ram_r) begin
            ram_w_en <= 1'b1;
            ram_w    <= 1'b1;
            state    <= E_WR;
          end else begin
            e_cnt         <= sat_inc(e_cnt);
            bus.erase_ack <= 1'b1;
            state         <= ACK;
          end
        end
        E_WR: begin
          ram_w_en      <= 1'b0;
          ram_w         <= 1'b0;
          e_cnt         <= sat_inc(e_cnt);
          f_cnt         <= f_cnt + 1'b1;
          bus.erase_ack <= 1'b1;
          state         <= ACK;
        end
        W_RD:  state <= W_CHK;
        W_CHK: begin
          bus.wl_rdata <= ram_r;
          bus.wl_ack   <= 1'b1;
          state        <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
